// File: rtl/snake_head_motion.sv
`timescale 1ns/1ps
// Two-player snake head motion: key decode, frame-paced grid stepping, wall/head collisions.
// Build option: define SNAKE_WRAP_EN to wrap heads at the grid edges instead of killing them.
module snake_head_motion #(
  parameter int STEP_FRAMES = 8,
  parameter int CELL        = 24,
  parameter int GRID_W      = 26,
  parameter int GRID_H      = 20
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [15:0] keycode,
  output logic [9:0]  snakeX_pos,
  output logic [9:0]  snakeY_pos,
  output logic [9:0]  snake2X_pos,
  output logic [9:0]  snake2Y_pos,
  output logic [1:0]  motionFlag,
  output logic [1:0]  motionFlag1,
  output logic        step,
  output logic        dead1,
  output logic        dead2,
  output logic        game_over
);
  // state | meaning
  // IDLE  | waiting for first valid key, heads parked
  // RUN   | heads step every STEP_FRAMES frames
  // OVER  | a head died, everything frozen until reset
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_OVER} state_t;

  localparam logic [9:0] MIN_C  = 10'd12;
  localparam logic [9:0] X_MAX  = 10'(12 + CELL * (GRID_W - 1));
  localparam logic [9:0] Y_MAX  = 10'(12 + CELL * (GRID_H - 1));
  localparam logic [9:0] STEP_C = 10'(CELL);
  localparam logic [5:0] LAST   = 6'(STEP_FRAMES - 1);

  state_t      state, state_n;
  logic        fs1, fs2, fs3;
  logic [5:0]  fcnt;
  logic [1:0]  pend1, pend2;
  logic        k1v, k2v;
  logic [1:0]  k1d, k2d;
  logic        fedge, tick;
  logic        hit1, hit2, head_hit, nd1, nd2;
  logic [9:0]  nx1, ny1, nx2, ny2;

  function automatic logic [2:0] dec_p1(input logic [7:0] k);
    case (k)
      8'h1A:   return 3'b1_00;
      8'h04:   return 3'b1_01;
      8'h16:   return 3'b1_10;
      8'h07:   return 3'b1_11;
      default: return 3'b0_00;
    endcase
  endfunction

  function automatic logic [2:0] dec_p2(input logic [7:0] k);
    case (k)
      8'h52:   return 3'b1_00;
      8'h50:   return 3'b1_01;
      8'h51:   return 3'b1_10;
      8'h4F:   return 3'b1_11;
      default: return 3'b0_00;
    endcase
  endfunction

  // Returns {off_grid, new_x, new_y}; bounds are tested before the add/subtract.
  function automatic logic [20:0] move(input logic [9:0] x, input logic [9:0] y,
                                       input logic [1:0] dir);
    logic [9:0] nx, ny;
    logic       off;
    nx  = x;
    ny  = y;
    off = 1'b0;
    case (dir)
      2'b00:   if (y <= MIN_C) begin off = 1'b1; ny = Y_MAX; end else ny = y - STEP_C;
      2'b01:   if (x <= MIN_C) begin off = 1'b1; nx = X_MAX; end else nx = x - STEP_C;
      2'b10:   if (y >= Y_MAX) begin off = 1'b1; ny = MIN_C; end else ny = y + STEP_C;
      default: if (x >= X_MAX) begin off = 1'b1; nx = MIN_C; end else nx = x + STEP_C;
    endcase
`ifdef SNAKE_WRAP_EN
    return {1'b0, nx, ny};
`else
    if (off) return {1'b1, x, y};
    return {1'b0, nx, ny};
`endif
  endfunction

  always_comb begin
    state_n = state;
    {k1v, k1d} = dec_p1(keycode[7:0]);
    {k2v, k2d} = dec_p2(keycode[15:8]);
    fedge = fs2 & ~fs3;
    tick  = (state == S_RUN) && fedge && (fcnt == LAST);
    {hit1, nx1, ny1} = move(snakeX_pos, snakeY_pos, pend1);
    {hit2, nx2, ny2} = move(snake2X_pos, snake2Y_pos, pend2);
    head_hit = ((nx1 == nx2) && (ny1 == ny2)) ||
               ((nx1 == snake2X_pos) && (ny1 == snake2Y_pos) &&
                (nx2 == snakeX_pos) && (ny2 == snakeY_pos));
    nd1 = dead1 | hit1 | head_hit;
    nd2 = dead2 | hit2 | head_hit;
    case (state)
      S_IDLE:  if (k1v || k2v) state_n = S_RUN;
      S_RUN:   if (tick && (nd1 || nd2)) state_n = S_OVER;
      default: state_n = S_OVER;
    endcase
    game_over = (state == S_OVER);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      fs1 <= 1'b0; fs2 <= 1'b0; fs3 <= 1'b0;
      fcnt <= 6'd0;
      step <= 1'b0;
      snakeX_pos <= 10'd108; snakeY_pos <= 10'd228;
      snake2X_pos <= 10'd516; snake2Y_pos <= 10'd228;
      motionFlag <= 2'b11; motionFlag1 <= 2'b01;
      pend1 <= 2'b11; pend2 <= 2'b01;
      dead1 <= 1'b0; dead2 <= 1'b0;
    end else begin
      fs1 <= frame_clk;
      fs2 <= fs1;
      fs3 <= fs2;
      step <= tick;
      // Up/down and left/right differ only in bit 1, so reversal is dir ^ 2'b10.
      if (k1v && (k1d != (motionFlag ^ 2'b10)))  pend1 <= k1d;
      if (k2v && (k2d != (motionFlag1 ^ 2'b10))) pend2 <= k2d;
      if ((state == S_RUN) && fedge) fcnt <= (fcnt == LAST) ? 6'd0 : fcnt + 6'd1;
      if (tick) begin
        motionFlag  <= pend1;
        motionFlag1 <= pend2;
        snakeX_pos  <= nx1;
        snakeY_pos  <= ny1;
        snake2X_pos <= nx2;
        snake2Y_pos <= ny2;
        dead1 <= nd1;
        dead2 <= nd2;
      end
    end
  end
endmodule

// File: tb/tb_snake_head_motion.sv
`timescale 1ns/1ps
// Bench for snake_head_motion: table of key/step vectors scored against a queue of expected heads.
module tb_snake_head_motion;
  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        frame_clk = 1'b0;
  logic [15:0] keycode = 16'h0000;
  logic [9:0]  snakeX_pos, snakeY_pos, snake2X_pos, snake2Y_pos;
  logic [1:0]  motionFlag, motionFlag1;
  logic        step, dead1, dead2, game_over;

  snake_head_motion dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
    .snakeX_pos(snakeX_pos), .snakeY_pos(snakeY_pos),
    .snake2X_pos(snake2X_pos), .snake2Y_pos(snake2Y_pos),
    .motionFlag(motionFlag), .motionFlag1(motionFlag1),
    .step(step), .dead1(dead1), .dead2(dead2), .game_over(game_over)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0] k1, k2;
    int         x1, y1, x2, y2;
    int         m1, m2;
    int         d1, d2, go;
  } vec_t;

  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   steps_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input vec_t e);
    chk({tag, ".x1"}, snakeX_pos, e.x1);
    chk({tag, ".y1"}, snakeY_pos, e.y1);
    chk({tag, ".x2"}, snake2X_pos, e.x2);
    chk({tag, ".y2"}, snake2Y_pos, e.y2);
    chk({tag, ".mf"}, motionFlag, e.m1);
    chk({tag, ".mf1"}, motionFlag1, e.m2);
    chk({tag, ".dead1"}, dead1, e.d1);
    chk({tag, ".dead2"}, dead2, e.d2);
    chk({tag, ".game_over"}, game_over, e.go);
  endtask

  function automatic vec_t mk(input int x1, input int y1, input int x2, input int y2,
                              input int m1, input int m2, input int d1, input int d2,
                              input int go);
    vec_t v;
    v.k1 = 8'h00; v.k2 = 8'h00;
    v.x1 = x1; v.y1 = y1; v.x2 = x2; v.y2 = y2;
    v.m1 = m1; v.m2 = m2; v.d1 = d1; v.d2 = d2; v.go = go;
    return v;
  endfunction

  // Scoreboard: every step pulse consumes one expected record.
  always @(negedge Clk) begin
    if (step) begin
      vec_t e;
      steps_seen++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_step: got step=1 expected no step (x1=%0d x2=%0d)",
                 snakeX_pos, snake2X_pos);
      end else begin
        e = exp_q.pop_front();
        chk_vec($sformatf("step%0d", steps_seen), e);
      end
    end
  end

  task automatic frame_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      frame_clk = 1'b1;
      repeat (4) @(negedge Clk);
      frame_clk = 1'b0;
      repeat (4) @(negedge Clk);
    end
  endtask

  task automatic press(input logic [7:0] k1, input logic [7:0] k2);
    keycode = {k2, k1};
    repeat (2) @(negedge Clk);
    keycode = 16'h0000;
    @(negedge Clk);
  endtask

  task automatic wait_steps(input int target);
    int n = 0;
    while (steps_seen < target && n < 50) begin
      @(negedge Clk);
      n++;
    end
    chk("step_arrived", steps_seen >= target, 1);
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
  endtask

  task automatic run_step(input vec_t e);
    int target;
    target = steps_seen + 1;
    exp_q.push_back(e);
    frame_pulses(8);
    wait_steps(target);
  endtask

  vec_t tbl[7];
  vec_t rst_v;

  initial begin
    int base;
    rst_v = mk(108, 228, 516, 228, 3, 1, 0, 0, 0);
    tbl[0] = mk(132, 228, 492, 228, 3, 1, 0, 0, 0); tbl[0].k1 = 8'h07; tbl[0].k2 = 8'h00;
    tbl[1] = mk(156, 228, 468, 228, 3, 1, 0, 0, 0); tbl[1].k1 = 8'h04; tbl[1].k2 = 8'h00;
    tbl[2] = mk(156, 204, 444, 228, 0, 1, 0, 0, 0); tbl[2].k1 = 8'h1A; tbl[2].k2 = 8'h00;
    tbl[3] = mk(180, 204, 444, 204, 3, 0, 0, 0, 0); tbl[3].k1 = 8'h07; tbl[3].k2 = 8'h52;
    tbl[4] = mk(180, 228, 444, 180, 2, 0, 0, 0, 0); tbl[4].k1 = 8'h16; tbl[4].k2 = 8'h51;
    tbl[5] = mk(204, 228, 468, 180, 3, 3, 0, 0, 0); tbl[5].k1 = 8'h07; tbl[5].k2 = 8'h4F;
    tbl[6] = mk(228, 228, 492, 180, 3, 3, 0, 0, 0); tbl[6].k1 = 8'h52; tbl[6].k2 = 8'h1A;

    // Reset values, then IDLE must ignore frames.
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    chk_vec("reset", rst_v);
    chk("reset.step", step, 0);
    Reset = 1'b1;
    frame_pulses(10);
    chk("idle_steps", steps_seen, 0);
    chk_vec("idle", rst_v);

    // Table of key patterns, one step each.
    for (int i = 0; i < 7; i++) begin
      press(tbl[i].k1, tbl[i].k2);
      run_step(tbl[i]);
    end

    // Head-on approach: adjacent after 8 steps, swap cells on the 9th.
    do_reset();
    press(8'h07, 8'h00);
    for (int k = 1; k <= 9; k++) begin
      if (k < 9) run_step(mk(108 + 24 * k, 228, 516 - 24 * k, 228, 3, 1, 0, 0, 0));
      else       run_step(mk(324, 228, 300, 228, 3, 1, 1, 1, 1));
    end
    base = steps_seen;
    frame_pulses(10);
    chk("over_no_step", steps_seen, base);
    chk_vec("over_frozen", mk(324, 228, 300, 228, 3, 1, 1, 1, 1));

    // Left wall: P1 goes up, then left until x=12, then one more step.
    do_reset();
    press(8'h1A, 8'h00);
    run_step(mk(108, 204, 492, 228, 0, 1, 0, 0, 0));
    press(8'h04, 8'h00);
    for (int k = 2; k <= 6; k++) begin
      if (k < 6) run_step(mk(108 - 24 * (k - 1), 204, 516 - 24 * k, 228, 1, 1, 0, 0, 0));
`ifdef SNAKE_WRAP_EN
      else       run_step(mk(612, 204, 372, 228, 1, 1, 0, 0, 0));
`else
      else       run_step(mk(12, 204, 372, 228, 1, 1, 1, 0, 1));
`endif
    end

    // Reset held across the cycle where the 8th frame edge would step.
    do_reset();
    press(8'h07, 8'h00);
    frame_pulses(7);
    base = steps_seen;
    frame_clk = 1'b1;
    Reset = 1'b0;
    repeat (4) @(negedge Clk);
    frame_clk = 1'b0;
    chk_vec("rst_mid_step", rst_v);
    chk("rst_mid_step.step", step, 0);
    Reset = 1'b1;
    repeat (6) @(negedge Clk);
    chk("rst_mid_no_step", steps_seen, base);
    chk_vec("rst_mid_after", rst_v);

    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
